// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencing controller for the multi-cycle MIPS subset
// (addu, subu, ori, lw, sw, beq, j, lui). Each instruction walks through
// FETCH -> DECODE -> execute / memory / write-back states so that the datapath
// can share one ALU and one memory port across cycles.
//
// Optional build macro MEM_WAIT_EN: adds the memReady input. FETCH, MEM_RD and
// MEM_WR then stall until memory reports ready. Without the macro, memory
// always completes in one cycle.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       aluZero,
`ifdef MEM_WAIT_EN
  input  logic       memReady,
`endif
  output logic       pcReset,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       mem2Reg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrc,
  output logic [1:0] nPC_sel,
  output logic [1:0] ext_op,
  output logic [2:0] aluCtr,
  output logic       instDone,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXE_R   = 4'd2;
  localparam logic [3:0] S_EXE_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADR = 4'd4;
  localparam logic [3:0] S_MEM_RD  = 4'd5;
  localparam logic [3:0] S_MEM_WB  = 4'd6;
  localparam logic [3:0] S_MEM_WR  = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_WB_R    = 4'd10;
  localparam logic [3:0] S_WB_I    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;

  logic [3:0] state_reg;
  logic [3:0] state_next;
  logic       mem_ready;

  logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic is_rtype, is_itype, is_mem, is_legal;

`ifdef MEM_WAIT_EN
  assign mem_ready = memReady;
`else
  assign mem_ready = 1'b1;
`endif

  // Instruction class decode from the (stable) instruction register fields
  always_comb begin
    is_addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
    is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
    is_ori   = (op == OP_ORI);
    is_lui   = (op == OP_LUI);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_j     = (op == OP_J);
    is_rtype = is_addu || is_subu;
    is_itype = is_ori || is_lui;
    is_mem   = is_lw || is_sw;
    is_legal = is_rtype || is_itype || is_mem || is_beq || is_j;
  end

  // Next-state selection; memory states stall until the memory is ready
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_rtype)      state_next = S_EXE_R;
        else if (is_itype) state_next = S_EXE_I;
        else if (is_mem)   state_next = S_MEM_ADR;
        else if (is_beq)   state_next = S_BRANCH;
        else if (is_j)     state_next = S_JUMP;
        else               state_next = S_FETCH;
      end
      S_EXE_R:   state_next = S_WB_R;
      S_WB_R:    state_next = S_FETCH;
      S_EXE_I:   state_next = S_WB_I;
      S_WB_I:    state_next = S_FETCH;
      S_MEM_ADR: state_next = is_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:  state_next = S_FETCH;
      S_MEM_WR:  state_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  assign state   = state_reg;
  assign pcReset = reset;

  // Moore output decode; reset forces every strobe and select to zero
  always_comb begin
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    mem2Reg  = 1'b0;
    regDst   = 1'b0;
    regWrite = 1'b0;
    aluSrc   = 1'b0;
    nPC_sel  = 2'b00;
    ext_op   = 2'b00;
    aluCtr   = ALU_ADD;
    instDone = 1'b0;
    illegal  = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          memRead = 1'b1;
          irWrite = mem_ready;
          pcWrite = mem_ready;
        end
        S_DECODE: illegal = !is_legal;
        S_EXE_R: aluCtr = is_subu ? ALU_SUB : ALU_ADD;
        S_WB_R: begin
          aluCtr   = is_subu ? ALU_SUB : ALU_ADD;
          regDst   = 1'b1;
          regWrite = 1'b1;
          instDone = 1'b1;
        end
        S_EXE_I, S_WB_I: begin
          aluSrc = 1'b1;
          if (is_ori) begin
            aluCtr = ALU_OR;
            ext_op = 2'b00;
          end else if (is_lui) begin
            aluCtr = ALU_ADD;
            ext_op = 2'b10;
          end
          if (state_reg == S_WB_I) begin
            regWrite = 1'b1;
            instDone = 1'b1;
          end
        end
        S_MEM_ADR, S_MEM_RD, S_MEM_WR: begin
          aluSrc = 1'b1;
          ext_op = 2'b01;
          aluCtr = ALU_ADD;
          if (state_reg == S_MEM_RD) memRead = 1'b1;
          if (state_reg == S_MEM_WR) begin
            // write strobe held through any wait; completion only when ready
            memWrite = 1'b1;
            instDone = mem_ready;
          end
        end
        S_MEM_WB: begin
          mem2Reg  = 1'b1;
          regWrite = 1'b1;
          instDone = 1'b1;
        end
        S_BRANCH: begin
          aluCtr   = ALU_SUB;
          nPC_sel  = 2'b01;
          pcWrite  = aluZero;
          instDone = 1'b1;
        end
        S_JUMP: begin
          nPC_sel  = 2'b10;
          pcWrite  = 1'b1;
          instDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. A reference model expands each
// instruction into its expected per-cycle control trace; the driver pushes
// expectations as it applies stimulus and a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       aluZero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pcReset, pcWrite, irWrite, memRead, memWrite;
  logic       mem2Reg, regDst, regWrite, aluSrc, instDone, illegal;
  logic [1:0] nPC_sel, ext_op;
  logic [2:0] aluCtr;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .aluZero(aluZero),
`ifdef MEM_WAIT_EN
    .memReady(mem_ready),
`endif
    .pcReset(pcReset), .pcWrite(pcWrite), .irWrite(irWrite),
    .memRead(memRead), .memWrite(memWrite), .mem2Reg(mem2Reg),
    .regDst(regDst), .regWrite(regWrite), .aluSrc(aluSrc),
    .nPC_sel(nPC_sel), .ext_op(ext_op), .aluCtr(aluCtr),
    .instDone(instDone), .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcrst, pcw, irw, mrd, mwr, m2r, rdst, rw, asrc;
    logic [1:0] npc, ext;
    logic [2:0] alu;
    logic done, ill;
  } obs_t;

  typedef struct {
    obs_t e;
    logic rst;
    logic rdy;
  } cyc_t;

  obs_t  act;
  assign act = {state, pcReset, pcWrite, irWrite, memRead, memWrite, mem2Reg,
                regDst, regWrite, aluSrc, nPC_sel, ext_op, aluCtr, instDone, illegal};

  cyc_t  plan[$];
  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    force_w = -1;
  obs_t  mon_e;
  string mon_t;

  // Monitor: every expected cycle is compared against what the DUT shows
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      n_checks++;
      if (act !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got state=%0d ctl=%h, want state=%0d ctl=%h",
                 mon_t, act.st, act, mon_e.st, mon_e);
      end
    end
  end

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_J = 7, K_ILL = 8;

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00 && f == 6'h21) return K_ADDU;
    if (o == 6'h00 && f == 6'h23) return K_SUBU;
    if (o == 6'h0d) return K_ORI;
    if (o == 6'h0f) return K_LUI;
    if (o == 6'h23) return K_LW;
    if (o == 6'h2b) return K_SW;
    if (o == 6'h04) return K_BEQ;
    if (o == 6'h02) return K_J;
    return K_ILL;
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_ADDU: return "addu";
      K_SUBU: return "subu";
      K_ORI:  return "ori";
      K_LUI:  return "lui";
      K_LW:   return "lw";
      K_SW:   return "sw";
      K_BEQ:  return "beq";
      K_J:    return "j";
      default: return "illegal";
    endcase
  endfunction

  function automatic obs_t blank(input logic [3:0] s);
    obs_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic int pick_waits();
`ifdef MEM_WAIT_EN
    if (force_w >= 0) return force_w;
    return int'($urandom_range(0, 2));
`else
    return 0;
`endif
  endfunction

  task automatic add(input obs_t e, input logic rdy);
    cyc_t c;
    c.e = e;
    c.rst = 1'b0;
    c.rdy = rdy;
    plan.push_back(c);
  endtask

  task automatic add_reset(input logic [3:0] s);
    cyc_t c;
    c.e = blank(s);
    c.e.pcrst = 1'b1;
    c.rst = 1'b1;
    c.rdy = 1'(($urandom));
    plan.push_back(c);
  endtask

  // Reference model: expand one instruction into its cycle-by-cycle trace
  task automatic build(input int k, input logic z);
    obs_t e;
    int   w;
    w = pick_waits();
    repeat (w) begin
      e = blank(4'd0); e.mrd = 1'b1; add(e, 1'b0);
    end
    e = blank(4'd0); e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; add(e, 1'b1);
    e = blank(4'd1); e.ill = (k == K_ILL); add(e, 1'(($urandom)));
    case (k)
      K_ADDU, K_SUBU: begin
        e = blank(4'd2); e.alu = (k == K_SUBU) ? 3'b001 : 3'b000; add(e, 1'(($urandom)));
        e.st = 4'd10; e.rdst = 1'b1; e.rw = 1'b1; e.done = 1'b1; add(e, 1'(($urandom)));
      end
      K_ORI, K_LUI: begin
        e = blank(4'd3); e.asrc = 1'b1;
        e.alu = (k == K_ORI) ? 3'b011 : 3'b000;
        e.ext = (k == K_ORI) ? 2'b00 : 2'b10;
        add(e, 1'(($urandom)));
        e.st = 4'd11; e.rw = 1'b1; e.done = 1'b1; add(e, 1'(($urandom)));
      end
      K_LW, K_SW: begin
        e = blank(4'd4); e.asrc = 1'b1; e.ext = 2'b01; add(e, 1'(($urandom)));
        w = pick_waits();
        if (k == K_LW) begin
          e.st = 4'd5; e.mrd = 1'b1;
          repeat (w) add(e, 1'b0);
          add(e, 1'b1);
          e = blank(4'd6); e.m2r = 1'b1; e.rw = 1'b1; e.done = 1'b1; add(e, 1'(($urandom)));
        end else begin
          e.st = 4'd7; e.mwr = 1'b1;
          repeat (w) add(e, 1'b0);
          e.done = 1'b1; add(e, 1'b1);
        end
      end
      K_BEQ: begin
        e = blank(4'd8); e.alu = 3'b001; e.npc = 2'b01; e.pcw = z; e.done = 1'b1;
        add(e, 1'(($urandom)));
      end
      K_J: begin
        e = blank(4'd9); e.npc = 2'b10; e.pcw = 1'b1; e.done = 1'b1;
        add(e, 1'(($urandom)));
      end
      default: ;
    endcase
  endtask

  // Cut the planned trace at index cut and replace the rest with one reset cycle
  task automatic abort_at(input int cut);
    logic [3:0] s;
    s = plan[cut].e.st;
    while (plan.size() > cut) void'(plan.pop_back());
    add_reset(s);
  endtask

  // Apply the plan one cycle at a time, queueing each expectation as it goes
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input string nm);
    cyc_t c;
    int   n;
    n = plan.size();
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk);
      #1;
      reset = c.rst;
      op = o;
      funct = f;
      aluZero = z;
      mem_ready = c.rdy;
      exp_q.push_back(c.e);
      tag_q.push_back(nm);
    end
    $display("instr %s op=%b funct=%b zero=%0b cycles=%0d", nm, o, f, z, n);
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input bit abort);
    int k;
    int cut;
    k = classify(o, f);
    build(k, z);
    if (abort) begin
      cut = int'($urandom_range(0, plan.size() - 1));
      abort_at(cut);
      run(o, f, z, {kname(k), "+reset"});
    end else begin
      run(o, f, z, kname(k));
    end
  endtask

  logic [5:0] legal_ops [8];
  logic [5:0] r_op, r_fn;
  int         sel;
  int         cut;

  initial begin
    legal_ops[0] = 6'h00; legal_ops[1] = 6'h00; legal_ops[2] = 6'h0d; legal_ops[3] = 6'h0f;
    legal_ops[4] = 6'h23; legal_ops[5] = 6'h2b; legal_ops[6] = 6'h04; legal_ops[7] = 6'h02;

    // three reset cycles; the first has no defined state yet
    reset = 1'b1;
    @(posedge clk);
    add_reset(4'd0);
    add_reset(4'd0);
    run(6'h00, 6'h21, 1'b0, "reset");

    do_instr(6'h00, 6'h21, 1'b0, 1'b0);   // addu
    do_instr(6'h00, 6'h23, 1'b0, 1'b0);   // subu
    do_instr(6'h23, 6'h00, 1'b0, 1'b0);   // lw
    do_instr(6'h04, 6'h00, 1'b1, 1'b0);   // beq taken
    do_instr(6'h04, 6'h00, 1'b0, 1'b0);   // beq not taken
    do_instr(6'h3f, 6'h00, 1'b0, 1'b0);   // illegal op
    do_instr(6'h0d, 6'h00, 1'b0, 1'b0);   // ori
    do_instr(6'h0f, 6'h00, 1'b0, 1'b0);   // lui
    do_instr(6'h02, 6'h00, 1'b0, 1'b0);   // j

    // sw aborted by reset on its first MEM_WR cycle
    build(K_SW, 1'b0);
    cut = 0;
    while (plan[cut].e.st != 4'd7) cut++;
    abort_at(cut);
    run(6'h2b, 6'h00, 1'b0, "sw+reset");
    do_instr(6'h2b, 6'h00, 1'b0, 1'b0);   // sw completes normally afterwards

`ifdef MEM_WAIT_EN
    force_w = 0;
    build(K_SW, 1'b0);
    while (plan.size() > 0) void'(plan.pop_back());
    // FETCH ready at once, MEM_WR stalled for two cycles
    force_w = 0; build(K_SW, 1'b0);
    plan.delete();
    begin
      obs_t e;
      e = blank(4'd0); e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; add(e, 1'b1);
      e = blank(4'd1); add(e, 1'b1);
      e = blank(4'd4); e.asrc = 1'b1; e.ext = 2'b01; add(e, 1'b1);
      e.st = 4'd7; e.mwr = 1'b1; add(e, 1'b0); add(e, 1'b0);
      e.done = 1'b1; add(e, 1'b1);
    end
    run(6'h2b, 6'h00, 1'b0, "sw-wait2");
    force_w = -1;
`endif

    // randomized instruction stream with occasional reset aborts
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 11));
      r_fn = 6'($urandom);
      if (sel < 8) begin
        r_op = legal_ops[sel];
        if (sel == 0) r_fn = 6'h21;
        if (sel == 1) r_fn = 6'h23;
      end else if (sel == 8) begin
        r_op = 6'h00;
      end else begin
        r_op = 6'($urandom);
      end
      do_instr(r_op, r_fn, 1'($urandom), ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
